xtea_arbiter: RTL and testbench

Shares one XTEA encrypt/decrypt core between two independent requesters. Each requester presents a 128-bit block, a 128-bit key and a mode bit over a valid/ready handshake. The arbiter picks one requester round-robin, launches the core with a single start pulse, waits for the core's ready pulse and returns the result to the owning requester over a held response handshake. It sits between the system-level clients and the core's start/configuration/data_i/key/ready/data_o ports, and adds a timeout so that a hung core cannot lock out both clients.

---
 rtl/xtea_arbiter_if.sv | 22 ++
 rtl/xtea_arbiter.sv | 146 ++++++++++++++
 tb/tb_xtea_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xtea_arbiter_if.sv
// Requester-side channel of the XTEA arbiter: job request handshake plus held response.
interface xtea_arbiter_if;
  logic         req_valid;
  logic         req_config;
  logic [127:0] req_data;
  logic [127:0] req_key;
  logic         req_ready;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic         resp_err;
  logic         resp_ack;

  modport master (
    output req_valid, req_config, req_data, req_key, resp_ack,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_config, req_data, req_key, resp_ack,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/xtea_arbiter.sv
// Round-robin arbiter sharing one XTEA core between two requesters, with a run timeout
// so a hung core returns an error response instead of locking out both clients.
module xtea_arbiter #(
  parameter int unsigned Timeout  = 4096,
  parameter int unsigned Cooldown = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  xtea_arbiter_if.slave ch0_if,
  xtea_arbiter_if.slave ch1_if,
  output logic          core_start_o,
  output logic          core_config_o,
  output logic [127:0]  core_data_o,
  output logic [127:0]  core_key_o,
  input  logic          core_ready_i,
  input  logic [127:0]  core_result_i
);

  localparam int unsigned TimerW = (Timeout > 2) ? $clog2(Timeout) : 1;
  localparam int unsigned CoolW  = (Cooldown > 0) ? $clog2(Cooldown + 1) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StRun, StResp, StCool} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [CoolW-1:0]    cool_q, cool_d;
  logic                err_q, err_d;
  logic [1:0][127:0]   resp_data_q, resp_data_d;
  logic                cfg_q, cfg_d;
  logic [127:0]        data_q, data_d;
  logic [127:0]        key_q, key_d;

  logic [1:0]          req_v;
  logic                grant;
  logic                own_ack;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    cool_d       = cool_q;
    err_d        = err_q;
    resp_data_d  = resp_data_q;
    cfg_d        = cfg_q;
    data_d       = data_q;
    key_d        = key_q;

    req_v   = {ch1_if.req_valid, ch0_if.req_valid};
    grant   = (&req_v) ? ~last_grant_q : req_v[1];
    own_ack = owner_q ? ch1_if.resp_ack : ch0_if.resp_ack;

    unique case (state_q)
      StIdle: begin
        if (|req_v) begin
          owner_d      = grant;
          last_grant_d = grant;
          cfg_d        = grant ? ch1_if.req_config : ch0_if.req_config;
          data_d       = grant ? ch1_if.req_data   : ch0_if.req_data;
          key_d        = grant ? ch1_if.req_key    : ch0_if.req_key;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StRun;
      end
      StRun: begin
        timer_d = timer_q + TimerW'(1);
        if (core_ready_i) begin
          resp_data_d[owner_q] = core_result_i;
          err_d                = 1'b0;
          state_d              = StResp;
        end else if (timer_q == TimerW'(Timeout - 2)) begin
          // Counter would reach Timeout-1 this cycle: give up, keep stale data.
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (own_ack) begin
          if (Cooldown == 0) begin
            state_d = StIdle;
          end else begin
            cool_d  = CoolW'(Cooldown);
            state_d = StCool;
          end
        end
      end
      StCool: begin
        cool_d = cool_q - CoolW'(1);
        if (cool_q <= CoolW'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      cool_q       <= '0;
      err_q        <= 1'b0;
      resp_data_q  <= '0;
      cfg_q        <= 1'b0;
      data_q       <= '0;
      key_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      cool_q       <= cool_d;
      err_q        <= err_d;
      resp_data_q  <= resp_data_d;
      cfg_q        <= cfg_d;
      data_q       <= data_d;
      key_q        <= key_d;
    end
  end

  logic in_issue, in_resp;
  assign in_issue = (state_q == StIssue);
  assign in_resp  = (state_q == StResp);

  assign core_start_o  = in_issue;
  assign core_config_o = cfg_q;
  assign core_data_o   = data_q;
  assign core_key_o    = key_q;

  assign ch0_if.req_ready  = in_issue & ~owner_q;
  assign ch1_if.req_ready  = in_issue & owner_q;
  assign ch0_if.resp_valid = in_resp & ~owner_q;
  assign ch1_if.resp_valid = in_resp & owner_q;
  assign ch0_if.resp_err   = in_resp & ~owner_q & err_q;
  assign ch1_if.resp_err   = in_resp & owner_q & err_q;
  assign ch0_if.resp_data  = resp_data_q[0];
  assign ch1_if.resp_data  = resp_data_q[1];

endmodule

// File: tb/tb_xtea_arbiter.sv
// Directed/randomized bench for xtea_arbiter with a behavioural XTEA core and grant model.
module tb_xtea_arbiter;
  localparam int unsigned Timeout  = 48;
  localparam int unsigned Cooldown = 2;
  localparam int          Bound    = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  xtea_arbiter_if ch0_if ();
  xtea_arbiter_if ch1_if ();

  logic         core_start, core_config, core_ready;
  logic [127:0] core_data, core_key, core_result;

  xtea_arbiter #(
    .Timeout (Timeout),
    .Cooldown(Cooldown)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ch0_if       (ch0_if),
    .ch1_if       (ch1_if),
    .core_start_o (core_start),
    .core_config_o(core_config),
    .core_data_o  (core_data),
    .core_key_o   (core_key),
    .core_ready_i (core_ready),
    .core_result_i(core_result)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  logic tb_last;
  int   core_lat = 10;
  logic core_hang = 1'b0;
  logic inject_ready = 1'b0;

  // Reference XTEA on one 64-bit half, 32 cycles.
  function automatic logic [63:0] xtea64(input logic enc, input logic [63:0] blk,
                                         input logic [127:0] key);
    logic [31:0] v0, v1, sum;
    logic [31:0] k [4];
    v0 = blk[63:32];
    v1 = blk[31:0];
    for (int i = 0; i < 4; i++) k[i] = key[127-32*i -: 32];
    if (enc) begin
      sum = 32'h0;
      for (int r = 0; r < 32; r++) begin
        v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
        sum += 32'h9E3779B9;
        v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
      end
    end else begin
      sum = 32'hC6EF3720;
      for (int r = 0; r < 32; r++) begin
        v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
        sum -= 32'h9E3779B9;
        v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
      end
    end
    return {v0, v1};
  endfunction

  function automatic logic [127:0] xtea128(input logic enc, input logic [127:0] blk,
                                           input logic [127:0] key);
    return {xtea64(enc, blk[127:64], key), xtea64(enc, blk[63:0], key)};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round-robin rule: on a tie the channel not granted last time wins.
  function automatic int pick(input logic p0, input logic p1);
    if (p0 && p1) return tb_last ? 0 : 1;
    return p1 ? 1 : 0;
  endfunction

  function automatic logic resp_v(input int ch);
    return (ch == 1) ? ch1_if.resp_valid : ch0_if.resp_valid;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic cfg, input logic [127:0] d,
                         input logic [127:0] k);
    if (ch == 1) begin
      ch1_if.req_valid = 1'b1; ch1_if.req_config = cfg; ch1_if.req_data = d; ch1_if.req_key = k;
    end else begin
      ch0_if.req_valid = 1'b1; ch0_if.req_config = cfg; ch0_if.req_data = d; ch0_if.req_key = k;
    end
  endtask

  task automatic drop(input int ch);
    if (ch == 1) ch1_if.req_valid = 1'b0;
    else         ch0_if.req_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, {ch1_if.req_ready, ch0_if.req_ready}, 2'b00);
    check({tag, "_rvalid"}, {ch1_if.resp_valid, ch0_if.resp_valid}, 2'b00);
    check({tag, "_rerr"}, {ch1_if.resp_err, ch0_if.resp_err}, 2'b00);
    check({tag, "_rdata0"}, ch0_if.resp_data, '0);
    check({tag, "_rdata1"}, ch1_if.resp_data, '0);
    check({tag, "_core"}, {core_start, core_config}, 2'b00);
    check({tag, "_cdata"}, core_data, '0);
    check({tag, "_ckey"}, core_key, '0);
  endtask

  task automatic wait_start(input string tag, input int exp_ch, input logic exp_cfg,
                            input logic [127:0] exp_d, input logic [127:0] exp_k,
                            output int scyc);
    int n = 0;
    do begin @(negedge clk); n++; end while (!core_start && n < Bound);
    check({tag, "_start"}, core_start, 1'b1);
    check({tag, "_grant"}, {ch1_if.req_ready, ch0_if.req_ready},
          (exp_ch == 1) ? 2'b10 : 2'b01);
    check({tag, "_cfg"}, core_config, exp_cfg);
    check({tag, "_data"}, core_data, exp_d);
    check({tag, "_key"}, core_key, exp_k);
    scyc = cyc;
    tb_last = (exp_ch == 1);
  endtask

  task automatic wait_resp(input string tag, input int ch, input int bound, output int rcyc);
    int n = 0;
    int starts = 0;
    do begin
      @(negedge clk); n++;
      if (core_start) starts++;
    end while (!resp_v(ch) && n < bound);
    check({tag, "_rvalid"}, resp_v(ch), 1'b1);
    check({tag, "_no_restart"}, starts, 0);
    check({tag, "_other_quiet"}, resp_v(1 - ch), 1'b0);
    rcyc = cyc;
  endtask

  task automatic do_ack(input string tag, input int ch, input int hold, output int cack);
    repeat (hold) @(negedge clk);
    check({tag, "_held"}, resp_v(ch), 1'b1);
    if (ch == 1) ch1_if.resp_ack = 1'b1; else ch0_if.resp_ack = 1'b1;
    cack = cyc;
    @(negedge clk);
    ch0_if.resp_ack = 1'b0;
    ch1_if.resp_ack = 1'b0;
    check({tag, "_cleared"}, resp_v(ch), 1'b0);
  endtask

  task automatic pulse_stray_ready();
    #1 inject_ready = 1'b1;
    @(negedge clk);
    #1 inject_ready = 1'b0;
  endtask

  // Behavioural core: result pulse core_lat cycles after the start pulse.
  initial begin
    logic         busy;
    int           cnt;
    logic [127:0] job_res;
    busy = 1'b0; cnt = 0; job_res = '0;
    core_ready = 1'b0; core_result = '0;
    forever begin
      @(negedge clk);
      core_ready = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        if (inject_ready) begin
          core_ready  = 1'b1;
          core_result = 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D;
        end
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            core_ready  = 1'b1;
            core_result = job_res;
            busy        = 1'b0;
          end
        end
        if (core_start && !core_hang) begin
          busy    = 1'b1;
          cnt     = core_lat;
          job_res = xtea128(core_config, core_data, core_key);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] a, b, p, k, c, res;
    logic [127:0] jd [2];
    logic [127:0] jk [2];
    logic         jc [2];
    logic [127:0] last_r [2];
    int           s, s_prev, r, cack, v, e, quiet;

    ch0_if.req_valid = 1'b0; ch0_if.req_config = 1'b0; ch0_if.req_data = '0;
    ch0_if.req_key = '0; ch0_if.resp_ack = 1'b0;
    ch1_if.req_valid = 1'b0; ch1_if.req_config = 1'b0; ch1_if.req_data = '0;
    ch1_if.req_key = '0; ch1_if.resp_ack = 1'b0;
    last_r[0] = '0; last_r[1] = '0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    #1 rst_n = 1'b1;
    tb_last = 1'b1;

    // Single encrypt on channel 0, key=0 data=0, 40-cycle core.
    @(negedge clk);
    core_lat = 40;
    set_req(0, 1'b1, '0, '0);
    v = cyc;
    wait_start("t1", pick(1'b1, 1'b0), 1'b1, '0, '0, s);
    check("t1_grant_latency", s - v, 1);
    drop(0);
    wait_resp("t1", 0, Timeout + 10, r);
    check("t1_result_latency", r - s, core_lat + 1);
    res = xtea128(1'b1, '0, '0);
    check("t1_data", ch0_if.resp_data, res);
    check("t1_err", ch0_if.resp_err, 1'b0);
    last_r[0] = res;
    do_ack("t1", 0, 3, cack);
    check("t1_ch1_quiet", ch1_if.resp_valid, 1'b0);

    // Fresh reset, both request together: channel 0 first, channel 1 after cooldown.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tb_last = 1'b1;
    last_r[0] = '0; last_r[1] = '0;
    @(negedge clk);
    core_lat = 5;
    a = rand128(); b = rand128(); k = rand128();
    set_req(0, 1'b1, a, k);
    set_req(1, 1'b0, b, k);
    wait_start("t2a", pick(1'b1, 1'b1), 1'b1, a, k, s);
    drop(0);
    wait_resp("t2a", 0, Timeout + 10, r);
    check("t2a_data", ch0_if.resp_data, xtea128(1'b1, a, k));
    last_r[0] = xtea128(1'b1, a, k);
    do_ack("t2a", 0, 0, cack);
    wait_start("t2b", pick(1'b0, 1'b1), 1'b0, b, k, s);
    check("t2b_cooldown_gap", s - cack, Cooldown + 2);
    drop(1);
    wait_resp("t2b", 1, Timeout + 10, r);
    check("t2b_data", ch1_if.resp_data, xtea128(1'b0, b, k));
    last_r[1] = xtea128(1'b0, b, k);
    do_ack("t2b", 1, 1, cack);

    // Both channels continuously valid: grants alternate, jobs captured at grant.
    for (int ch = 0; ch < 2; ch++) begin
      jc[ch] = 1'($urandom_range(0, 1)); jd[ch] = rand128(); jk[ch] = rand128();
      set_req(ch, jc[ch], jd[ch], jk[ch]);
    end
    s_prev = -1000;
    for (int j = 0; j < 6; j++) begin
      e = pick(1'b1, 1'b1);
      core_lat = $urandom_range(1, 20);
      wait_start("rr", e, jc[e], jd[e], jk[e], s);
      if (j > 0) check("rr_start_gap", (s - s_prev) >= int'(Cooldown + 4), 1'b1);
      s_prev = s;
      res = xtea128(jc[e], jd[e], jk[e]);
      jc[e] = 1'($urandom_range(0, 1)); jd[e] = rand128(); jk[e] = rand128();
      set_req(e, jc[e], jd[e], jk[e]);
      wait_resp("rr", e, Timeout + 10, r);
      check("rr_latency", r - s, core_lat + 1);
      check("rr_data", (e == 1) ? ch1_if.resp_data : ch0_if.resp_data, res);
      check("rr_err", (e == 1) ? ch1_if.resp_err : ch0_if.resp_err, 1'b0);
      last_r[e] = res;
      do_ack("rr", e, $urandom_range(0, 3), cack);
    end
    drop(0);
    drop(1);

    // Hung core: error response exactly Timeout cycles after ISSUE, stale data kept.
    core_hang = 1'b1;
    @(negedge clk);
    a = rand128(); k = rand128();
    set_req(0, 1'b1, a, k);
    wait_start("to", pick(1'b1, 1'b0), 1'b1, a, k, s);
    drop(0);
    wait_resp("to", 0, Timeout + 10, r);
    check("to_latency", r - s, Timeout);
    check("to_err", ch0_if.resp_err, 1'b1);
    check("to_data_kept", ch0_if.resp_data, last_r[0]);
    do_ack("to", 0, 1, cack);
    core_hang = 1'b0;
    pulse_stray_ready();
    pulse_stray_ready();
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (ch0_if.resp_valid || ch1_if.resp_valid || core_start) quiet++;
    end
    check("stray_ready_ignored", quiet, 0);
    check("stray_data_untouched", ch0_if.resp_data, last_r[0]);

    // Reset while RUN aborts the job; afterwards channel 1 is served normally.
    core_lat = 30;
    a = rand128(); k = rand128();
    set_req(0, 1'b0, a, k);
    wait_start("rst", pick(1'b1, 1'b0), 1'b0, a, k, s);
    drop(0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 check_zero("midrun_reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    tb_last = 1'b1;
    @(negedge clk);
    core_lat = 7;
    b = rand128(); k = rand128();
    set_req(1, 1'b1, b, k);
    v = cyc;
    wait_start("post_rst", pick(1'b0, 1'b1), 1'b1, b, k, s);
    check("post_rst_grant_latency", s - v, 1);
    drop(1);
    wait_resp("post_rst", 1, Timeout + 10, r);
    check("post_rst_data", ch1_if.resp_data, xtea128(1'b1, b, k));
    check("post_rst_ch0_data", ch0_if.resp_data, '0);
    do_ack("post_rst", 1, 0, cack);

    // Encrypt on channel 0, decrypt the result on channel 1: plaintext comes back.
    p = rand128(); k = rand128();
    core_lat = $urandom_range(1, 40);
    set_req(0, 1'b1, p, k);
    wait_start("enc", pick(1'b1, 1'b0), 1'b1, p, k, s);
    drop(0);
    wait_resp("enc", 0, Timeout + 10, r);
    c = ch0_if.resp_data;
    check("enc_data", c, xtea128(1'b1, p, k));
    do_ack("enc", 0, 0, cack);
    core_lat = $urandom_range(1, 40);
    set_req(1, 1'b0, c, k);
    wait_start("dec", pick(1'b0, 1'b1), 1'b0, c, k, s);
    drop(1);
    wait_resp("dec", 1, Timeout + 10, r);
    check("dec_roundtrip", ch1_if.resp_data, p);
    check("dec_err", ch1_if.resp_err, 1'b0);
    do_ack("dec", 1, 2, cack);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
